dma_req_arb: RTL and testbench

- Multi-channel request arbiter for the next-generation multi-channel DMA core.
- Merges NUM_CH independent slice request streams (one per channel) onto a single AXI address-request port.
- Tags each request with its channel ID and enforces a per-channel outstanding-transaction limit, tracked from completions.
- Instantiated twice in the core: once for the read (AR) path, once for the write (AW) path, between the per-channel slices and the AXI front end.

---
 rtl/dma_pkg.sv | 23 ++
 rtl/dma_rr_pick.sv | 50 +++++
 rtl/dma_req_arb.sv | 192 +++++++++++++++++++
 tb/tb_dma_req_arb.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types, field widths and helpers for the DMA request arbiter
//
// Purpose: arbitration-mode encodings, request field widths and the clamp
// that turns the programmed outstanding limit into the limit actually applied.
package dma_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  localparam int unsigned ALEN_W = 8;
  localparam int unsigned SIZE_W = 3;

  // A programmed limit of 0, or one above the hard ceiling, falls back to the ceiling.
  function automatic int unsigned eff_max(input int unsigned cfg_max, input int unsigned hard_max);
    if (cfg_max == 0 || cfg_max > hard_max) begin
      return hard_max;
    end
    return cfg_max;
  endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// rtl/dma_rr_pick.sv - N-way priority picker with a rotating search base
//
// Purpose: picks one requester, searching upward from i_base with wrap-around
// (round-robin) or from index 0 (fixed priority, lowest index wins).
// Ports:
//   i_req    N-bit request vector
//   i_base   search start index (ignored in fixed mode)
//   i_mode   arbitration mode (arb_mode_e encoding)
//   o_grant  one-hot grant, zero when nothing requests
//   o_idx    encoded index of the granted requester
//   o_valid  1 when some requester was picked
module dma_rr_pick
  import dma_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_base,
  input  logic         i_mode,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  logic [W-1:0]   w_start;
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;

  always_comb begin
    w_start = (i_mode == ARB_FIXED) ? '0 : i_base;
    // Doubling the vector then shifting gives a rotation where bit k is
    // requester (start + k) mod N, so the lowest set bit is the winner.
    w_dbl   = {i_req, i_req} >> w_start;
    w_rot   = w_dbl[N-1:0];
    o_valid = 1'b0;
    o_idx   = '0;
    o_grant = '0;
    for (int off = N - 1; off >= 0; off--) begin
      if (w_rot[off]) begin
        o_valid = 1'b1;
        o_idx   = W'((int'(w_start) + off) % N);
      end
    end
    if (o_valid) begin
      o_grant[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/dma_req_arb.sv
// rtl/dma_req_arb.sv - multi-channel burst request arbiter with per-channel outstanding limit
//
// Purpose: merges NUM_CH channel request streams onto one AXI address port,
// tags each burst with its channel as the ID, and stops granting a channel
// once its issued-but-uncompleted bursts reach the effective limit.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cfg_arb_mode         0 round-robin, 1 fixed priority
//   cfg_max_outs         per-channel outstanding limit (0 / too large = MAX_OUTS)
//   req_valid/req_ready  per-channel handshake; req_* fields flattened per channel
//   out_*                registered merged request (one slot)
//   cpl_valid, cpl_id    burst completion
//   ch_outs, ch_idle     per-channel outstanding counts and idle flags
//   proto_err(_clr)      sticky bad-completion flag and its clear
module dma_req_arb
  import dma_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int ADDR_W   = 32,
  parameter  int ID_W     = 4,
  parameter  int MAX_OUTS = 8,
  localparam int CH_W     = $clog2(NUM_CH),
  localparam int OUTS_W   = $clog2(MAX_OUTS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_arb_mode,
  input  logic [OUTS_W-1:0]          cfg_max_outs,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*ALEN_W-1:0]   req_alen,
  input  logic [NUM_CH*SIZE_W-1:0]   req_size,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [ALEN_W-1:0]          out_alen,
  output logic [SIZE_W-1:0]          out_size,
  output logic [ID_W-1:0]            out_id,
  input  logic                       cpl_valid,
  input  logic [ID_W-1:0]            cpl_id,
  output logic [NUM_CH*OUTS_W-1:0]   ch_outs,
  output logic [NUM_CH-1:0]          ch_idle,
  output logic                       proto_err,
  input  logic                       proto_err_clr
);

  logic                r_valid;
  logic [ADDR_W-1:0]   r_addr;
  logic [ALEN_W-1:0]   r_alen;
  logic [SIZE_W-1:0]   r_size;
  logic [CH_W-1:0]     r_ch;
  logic [CH_W-1:0]     r_ptr;
  logic [OUTS_W-1:0]   r_outs [NUM_CH];
  logic                r_perr;

  logic [OUTS_W-1:0]   w_eff_max;
  logic [NUM_CH-1:0]   w_held;
  logic [OUTS_W:0]     w_pend [NUM_CH];
  logic [NUM_CH-1:0]   w_elig;
  logic [NUM_CH-1:0]   w_grant;
  logic [CH_W-1:0]     w_gidx;
  logic                w_gvalid;
  logic                w_can_load;
  logic                w_accept;
  logic                w_issue;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [ALEN_W-1:0]   w_sel_alen;
  logic [SIZE_W-1:0]   w_sel_size;
  logic [CH_W-1:0]     w_cpl_ch;
  logic                w_cpl_in_range;
  logic [NUM_CH-1:0]   w_inc;
  logic [NUM_CH-1:0]   w_dec;
  logic                w_cpl_bad;

  assign w_eff_max = OUTS_W'(eff_max(32'(cfg_max_outs), MAX_OUTS));

  // A request sitting in the slot has been granted but not yet counted, so it
  // counts against its channel's limit.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_held[i] = r_valid && (r_ch == CH_W'(i));
      w_pend[i] = (OUTS_W + 1)'(r_outs[i]) + (OUTS_W + 1)'(w_held[i]);
      w_elig[i] = req_valid[i] && (w_pend[i] < (OUTS_W + 1)'(w_eff_max));
    end
  end

  dma_rr_pick #(
    .N (NUM_CH),
    .W (CH_W)
  ) u_pick (
    .i_req   (w_elig),
    .i_base  (r_ptr),
    .i_mode  (cfg_arb_mode),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_valid (w_gvalid)
  );

  assign w_can_load = !r_valid || out_ready;
  assign req_ready  = (w_can_load && !rst) ? w_grant : '0;
  assign w_accept   = w_gvalid && w_can_load && !rst;
  assign w_issue    = r_valid && out_ready;

  always_comb begin
    w_sel_addr = '0;
    w_sel_alen = '0;
    w_sel_size = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_alen = req_alen[i*ALEN_W +: ALEN_W];
        w_sel_size = req_size[i*SIZE_W +: SIZE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_alen  <= '0;
      r_size  <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_addr  <= w_sel_addr;
        r_alen  <= w_sel_alen;
        r_size  <= w_sel_size;
        r_ch    <= w_gidx;
        r_ptr   <= (w_gidx == CH_W'(NUM_CH - 1)) ? '0 : w_gidx + CH_W'(1);
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign w_cpl_ch       = cpl_id[CH_W-1:0];
  assign w_cpl_in_range = (32'(cpl_id) < 32'(NUM_CH));

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_inc[i] = w_issue && (r_ch == CH_W'(i)) && (r_outs[i] != OUTS_W'(MAX_OUTS));
      w_dec[i] = cpl_valid && w_cpl_in_range && (w_cpl_ch == CH_W'(i)) && (r_outs[i] != '0);
    end
    // A valid completion that decrements nothing was out of range or hit a zero count.
    w_cpl_bad = cpl_valid && !(|w_dec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_outs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_outs[i] <= r_outs[i] + OUTS_W'(1);
        end else if (w_dec[i] && !w_inc[i]) begin
          r_outs[i] <= r_outs[i] - OUTS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perr <= 1'b0;
    end else if (w_cpl_bad) begin
      r_perr <= 1'b1;
    end else if (proto_err_clr) begin
      r_perr <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_addr  = r_addr;
  assign out_alen  = r_alen;
  assign out_size  = r_size;
  assign out_id    = ID_W'(r_ch);
  assign proto_err = r_perr;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_outs[i*OUTS_W +: OUTS_W] = r_outs[i];
      ch_idle[i]                  = (r_outs[i] == '0) && !w_held[i];
    end
  end

endmodule

// File: tb/tb_dma_req_arb.sv
// tb/tb_dma_req_arb.sv - self-checking bench for dma_req_arb
module tb_dma_req_arb;
  localparam int NUM_CH   = 4;
  localparam int ADDR_W   = 32;
  localparam int ID_W     = 4;
  localparam int MAX_OUTS = 8;
  localparam int OUTS_W   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     cfg_arb_mode;
  logic [OUTS_W-1:0]        cfg_max_outs;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*8-1:0]      req_alen;
  logic [NUM_CH*3-1:0]      req_size;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDR_W-1:0]        out_addr;
  logic [7:0]               out_alen;
  logic [2:0]               out_size;
  logic [ID_W-1:0]          out_id;
  logic                     cpl_valid;
  logic [ID_W-1:0]          cpl_id;
  logic [NUM_CH*OUTS_W-1:0] ch_outs;
  logic [NUM_CH-1:0]        ch_idle;
  logic                     proto_err;
  logic                     proto_err_clr;

  dma_req_arb #(
    .NUM_CH   (NUM_CH),
    .ADDR_W   (ADDR_W),
    .ID_W     (ID_W),
    .MAX_OUTS (MAX_OUTS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_arb_mode  (cfg_arb_mode),
    .cfg_max_outs  (cfg_max_outs),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_alen      (req_alen),
    .req_size      (req_size),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .out_alen      (out_alen),
    .out_size      (out_size),
    .out_id        (out_id),
    .cpl_valid     (cpl_valid),
    .cpl_id        (cpl_id),
    .ch_outs       (ch_outs),
    .ch_idle       (ch_idle),
    .proto_err     (proto_err),
    .proto_err_clr (proto_err_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_CH; i++) begin
      req_addr[i*32 +: 32] = $urandom;
      req_alen[i*8 +: 8]   = 8'($urandom);
      req_size[i*3 +: 3]   = 3'($urandom);
    end
  endtask

  // Reference model: a queue of at most one held request, a count per channel.
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  alen;
    logic [2:0]  size;
    int          ch;
  } req_t;

  req_t m_slot[$];
  int   m_outs[NUM_CH];
  int   m_ptr  = 0;
  bit   m_perr = 1'b0;
  bit   model_en = 1'b0;

  initial begin
    int          win, eff, c, pend;
    bit          can_load, bad;
    req_t        r;
    logic [3:0]  e_rr;
    logic [15:0] e_outs;
    logic [3:0]  e_idle;
    m_outs = '{default: 0};
    forever begin
      @(negedge clk);
      win = -1;
      if (model_en) begin
        eff = (cfg_max_outs == 0 || int'(cfg_max_outs) > MAX_OUTS) ? MAX_OUTS : int'(cfg_max_outs);
        can_load = (m_slot.size() == 0) || out_ready;
        if (can_load && !rst) begin
          for (int k = 0; k < NUM_CH; k++) begin
            c = cfg_arb_mode ? k : (m_ptr + k) % NUM_CH;
            pend = m_outs[c] + ((m_slot.size() != 0 && m_slot[0].ch == c) ? 1 : 0);
            if (win < 0 && req_valid[c] && pend < eff) win = c;
          end
        end
        e_rr = (win >= 0) ? 4'(1 << win) : 4'b0;
        e_outs = '0;
        e_idle = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          e_outs[i*4 +: 4] = 4'(m_outs[i]);
          e_idle[i] = (m_outs[i] == 0) && !(m_slot.size() != 0 && m_slot[0].ch == i);
        end
        chk("model req_ready", 64'(req_ready), 64'(e_rr));
        chk("model out_valid", 64'(out_valid), 64'(m_slot.size() != 0));
        if (m_slot.size() != 0) begin
          chk("model out_addr", 64'(out_addr), 64'(m_slot[0].addr));
          chk("model out_alen", 64'(out_alen), 64'(m_slot[0].alen));
          chk("model out_size", 64'(out_size), 64'(m_slot[0].size));
          chk("model out_id", 64'(out_id), 64'(m_slot[0].ch));
        end
        chk("model ch_outs", 64'(ch_outs), 64'(e_outs));
        chk("model ch_idle", 64'(ch_idle), 64'(e_idle));
        chk("model proto_err", 64'(proto_err), 64'(m_perr));
      end
      @(posedge clk);
      if (model_en) begin
        if (rst) begin
          m_slot.delete();
          m_outs = '{default: 0};
          m_ptr  = 0;
          m_perr = 1'b0;
        end else begin
          bad = 1'b0;
          if (cpl_valid) begin
            if (int'(cpl_id) >= NUM_CH || m_outs[cpl_id] == 0) bad = 1'b1;
            else m_outs[cpl_id]--;
          end
          if (m_slot.size() != 0 && out_ready) begin
            m_outs[m_slot[0].ch]++;
            void'(m_slot.pop_front());
          end
          if (bad) m_perr = 1'b1;
          else if (proto_err_clr) m_perr = 1'b0;
          if (win >= 0) begin
            r.addr = req_addr[win*32 +: 32];
            r.alen = req_alen[win*8 +: 8];
            r.size = req_size[win*3 +: 3];
            r.ch   = win;
            m_slot.push_back(r);
            m_ptr = (win + 1) % NUM_CH;
          end
        end
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        mode;
    logic [3:0]  maxo;
    logic [3:0]  rv;
    logic        ordy;
    logic        cv;
    logic [3:0]  cid;
    logic        clr;
    logic [3:0]  e_rr;
    logic        e_ov;
    logic [3:0]  e_id;
    logic [15:0] e_outs;
    logic        e_perr;
  } vec_t;

  vec_t vt[$];

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    cpl_valid = 1'b0;
    proto_err_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [31:0] e_addr;
  logic [7:0]  e_alen;

  initial begin
    rst = 1'b1; cfg_arb_mode = 1'b0; cfg_max_outs = 4'd8; req_valid = '0;
    out_ready = 1'b0; cpl_valid = 1'b0; cpl_id = '0; proto_err_clr = 1'b0;
    rand_data();

    // cap at 2 on ch1, completion reopens it; then ch3 same-cycle issue+completion
    // and the proto_err set/clear rules.
    //                rst   mode  maxo  rv       ordy  cv    cid   clr    e_rr     e_ov  e_id  e_outs    e_perr
    vt.push_back('{1'b1, 1'b0, 4'd2, 4'b0000, 1'b1, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 4'd0, 16'h0000, 1'b0});
    vt.push_back('{1'b0, 1'b0, 4'd2, 4'b0010, 1'b1, 1'b0, 4'd0, 1'b0, 4'b0010, 1'b0, 4'd0, 16'h0000, 1'b0});
    vt.push_back('{1'b0, 1'b0, 4'd2, 4'b0010, 1'b1, 1'b0, 4'd0, 1'b0, 4'b0010, 1'b1, 4'd1, 16'h0000, 1'b0});
    vt.push_back('{1'b0, 1'b0, 4'd2, 4'b0010, 1'b1, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b1, 4'd1, 16'h0010, 1'b0});
    vt.push_back('{1'b0, 1'b0, 4'd2, 4'b0010, 1'b1, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 4'd0, 16'h0020, 1'b0});
    vt.push_back('{1'b0, 1'b0, 4'd2, 4'b0010, 1'b1, 1'b1, 4'd1, 1'b0, 4'b0000, 1'b0, 4'd0, 16'h0020, 1'b0});
    vt.push_back('{1'b0, 1'b0, 4'd2, 4'b0010, 1'b1, 1'b0, 4'd0, 1'b0, 4'b0010, 1'b0, 4'd0, 16'h0010, 1'b0});
    vt.push_back('{1'b0, 1'b0, 4'd2, 4'b0010, 1'b1, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b1, 4'd1, 16'h0010, 1'b0});
    vt.push_back('{1'b0, 1'b0, 4'd2, 4'b0010, 1'b1, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 4'd0, 16'h0020, 1'b0});
    vt.push_back('{1'b0, 1'b0, 4'd0, 4'b1000, 1'b1, 1'b0, 4'd0, 1'b0, 4'b1000, 1'b0, 4'd0, 16'h0020, 1'b0});
    vt.push_back('{1'b0, 1'b0, 4'd0, 4'b1000, 1'b1, 1'b0, 4'd0, 1'b0, 4'b1000, 1'b1, 4'd3, 16'h0020, 1'b0});
    vt.push_back('{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b1, 4'd3, 1'b0, 4'b0000, 1'b1, 4'd3, 16'h1020, 1'b0});
    vt.push_back('{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b1, 4'd2, 1'b0, 4'b0000, 1'b0, 4'd0, 16'h1020, 1'b0});
    vt.push_back('{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 4'd0, 16'h1020, 1'b1});
    vt.push_back('{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b1, 4'd2, 1'b1, 4'b0000, 1'b0, 4'd0, 16'h1020, 1'b1});
    vt.push_back('{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b0, 4'd0, 1'b1, 4'b0000, 1'b0, 4'd0, 16'h1020, 1'b1});
    vt.push_back('{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b1, 4'd7, 1'b0, 4'b0000, 1'b0, 4'd0, 16'h1020, 1'b0});
    vt.push_back('{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b1, 4'd1, 1'b0, 4'b0000, 1'b0, 4'd0, 16'h1020, 1'b1});
    vt.push_back('{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b1, 4'd3, 1'b0, 4'b0000, 1'b0, 4'd0, 16'h1010, 1'b1});
    vt.push_back('{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b0, 4'd0, 1'b1, 4'b0000, 1'b0, 4'd0, 16'h0010, 1'b1});
    vt.push_back('{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b1, 4'd1, 1'b0, 4'b0000, 1'b0, 4'd0, 16'h0010, 1'b0});
    vt.push_back('{1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 4'd0, 16'h0000, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    model_en = 1'b1;

    for (int r = 0; r < vt.size(); r++) begin
      rst = vt[r].rst; cfg_arb_mode = vt[r].mode; cfg_max_outs = vt[r].maxo;
      req_valid = vt[r].rv; out_ready = vt[r].ordy; cpl_valid = vt[r].cv;
      cpl_id = vt[r].cid; proto_err_clr = vt[r].clr;
      rand_data();
      @(negedge clk);
      chk($sformatf("vec%0d req_ready", r), 64'(req_ready), 64'(vt[r].e_rr));
      chk($sformatf("vec%0d out_valid", r), 64'(out_valid), 64'(vt[r].e_ov));
      if (vt[r].e_ov) chk($sformatf("vec%0d out_id", r), 64'(out_id), 64'(vt[r].e_id));
      chk($sformatf("vec%0d ch_outs", r), 64'(ch_outs), 64'(vt[r].e_outs));
      chk($sformatf("vec%0d proto_err", r), 64'(proto_err), 64'(vt[r].e_perr));
      @(posedge clk); #1;
    end

    // Round-robin fairness, completions returned the cycle after issue.
    do_reset();
    cfg_arb_mode = 1'b0; cfg_max_outs = 4'd8; req_valid = 4'hF; out_ready = 1'b1;
    rand_data();
    @(negedge clk);
    chk("rr first grant", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    for (int k = 0; k < 12; k++) begin
      cpl_valid = (k > 0);
      cpl_id = 4'((k + 3) % 4);
      rand_data();
      @(negedge clk);
      chk($sformatf("rr issue%0d valid", k), 64'(out_valid), 64'(1'b1));
      chk($sformatf("rr issue%0d id", k), 64'(out_id), 64'(k % 4));
      @(posedge clk); #1;
    end

    // Fixed priority: ch0 starves ch2 until it drops.
    do_reset();
    cfg_arb_mode = 1'b1; req_valid = 4'b0101; out_ready = 1'b1;
    @(negedge clk);
    chk("fixed first grant", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      cpl_valid = (k > 0); cpl_id = 4'd0;
      @(negedge clk);
      chk($sformatf("fixed cyc%0d grant", k), 64'(req_ready), 64'(4'b0001));
      chk($sformatf("fixed cyc%0d id", k), 64'(out_id), 64'(0));
      @(posedge clk); #1;
    end
    req_valid = 4'b0100; cpl_valid = 1'b1; cpl_id = 4'd0;
    @(negedge clk);
    chk("fixed ch2 grant", 64'(req_ready), 64'(4'b0100));
    @(posedge clk); #1;
    @(negedge clk);
    chk("fixed ch2 issued", 64'(out_id), 64'(2));
    @(posedge clk); #1;
    cpl_valid = 1'b0;

    // Backpressure: slot full, out_ready low for 5 cycles.
    do_reset();
    cfg_arb_mode = 1'b0; req_valid = 4'hF; out_ready = 1'b0;
    rand_data();
    e_addr = req_addr[31:0];
    e_alen = req_alen[7:0];
    @(negedge clk);
    chk("bp load grant", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      @(negedge clk);
      chk($sformatf("bp%0d out_valid", k), 64'(out_valid), 64'(1'b1));
      chk($sformatf("bp%0d out_addr", k), 64'(out_addr), 64'(e_addr));
      chk($sformatf("bp%0d out_alen", k), 64'(out_alen), 64'(e_alen));
      chk($sformatf("bp%0d out_id", k), 64'(out_id), 64'(0));
      chk($sformatf("bp%0d req_ready", k), 64'(req_ready), 64'(0));
      chk($sformatf("bp%0d ch_outs", k), 64'(ch_outs), 64'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("bp release valid", 64'(out_valid), 64'(1'b1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp after valid", 64'(out_valid), 64'(1'b0));
    chk("bp one issue", 64'(ch_outs), 64'(16'h0001));

    // Reset with 3 outstanding on ch0 and the slot full.
    @(posedge clk); #1;
    req_valid = 4'b0001;
    repeat (3) begin
      rand_data();
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("pre-reset outs", 64'(ch_outs), 64'(16'h0003));
    chk("pre-reset valid", 64'(out_valid), 64'(1'b1));
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 4'hF;
    @(negedge clk);
    chk("post-reset out_valid", 64'(out_valid), 64'(1'b0));
    chk("post-reset ch_outs", 64'(ch_outs), 64'(0));
    chk("post-reset ch_idle", 64'(ch_idle), 64'(4'hF));
    chk("post-reset fields", 64'({out_addr, out_alen, out_size, out_id}), 64'(0));
    chk("post-reset ptr", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) cfg_arb_mode = ~cfg_arb_mode;
      if ($urandom_range(0, 49) == 0) cfg_max_outs = 4'($urandom);
      req_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      cpl_valid = ($urandom_range(0, 9) < 4);
      cpl_id = 4'($urandom_range(0, 4));
      proto_err_clr = ($urandom_range(0, 19) == 0);
      rand_data();
      @(posedge clk); #1;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
